data_cache: RTL
===============

# data_cache

Direct-mapped, write-back, write-allocate data cache placed between the pipeline's memory stage and the word-wide data `Memory`. It is the initiator on the memory port. It drives `mem_addr`, `mem_din`, `mem_read` and `mem_write`, and samples the memory's combinational read data. Hits complete in the request cycle. Misses stall the CPU through a multi-cycle write-back and line-fill sequence.

## Interface
- `NUM_SETS`, 16: number of lines. Must be a power of two, at least 2.
- `WORDS_PER_LINE`, 4: words per line. Must be a power of two, at least 2.
- `clk` input 1: single clock. All state changes on the rising edge.
- `reset` input 1: asynchronous, active-low reset (asserted when 0).
- `cpu_addr` input 32: byte address. Bits [1:0] are ignored.
- `cpu_din` input 32: store data.
- `cpu_read` input 1: load request.
- `cpu_write` input 1: store request.
- `cpu_dout` output 32: load data. Valid when `cpu_ready` and `cpu_read` are both 1, otherwise 0.
- `cpu_ready` output 1: request completes this cycle.
- `mem_addr` output 32: byte address to memory. Always word-aligned.
- `mem_din` output 32: write data to memory.
- `mem_read` output 1: memory read strobe.
- `mem_write` output 1: memory write strobe. Memory commits on the rising edge.
- `mem_dout` input 32: memory read data. Combinational in `mem_addr` and `mem_read`.
- `hit_count` output 32: completed hits. Wraps at 2^32.
- `miss_count` output 32: misses. Wraps at 2^32.

## Operation
- Address split: offset = 2 + log2(`WORDS_PER_LINE`) low bits, then index = log2(`NUM_SETS`) bits, then tag = the remaining upper bits.
- Per line state: valid bit, dirty bit, tag, and `WORDS_PER_LINE` data words.
- FSM states:
  - COMPARE (reset state)
  - WRITEBACK
  - FILL
- COMPARE, request present and hit:
  - `cpu_ready`=1.
  - Read: `cpu_dout` = the addressed word.
  - Write: the word is written and dirty=1, both at the edge.
- COMPARE, request present and miss:
  - `cpu_ready`=0 and `miss_count`+1.
  - The miss is flagged. A flagged request that later completes is not counted as a hit.
  - Next state is WRITEBACK if the victim line is valid and dirty, else FILL.
- WRITEBACK: for word k = 0..W-1, one word per cycle:
  - `mem_write`=1.
  - `mem_addr` = {victim tag, index, k, 2'b00}.
  - `mem_din` = word k.
  - After word W-1 the next state is FILL.
- FILL: for word k = 0..W-1, one word per cycle:
  - `mem_read`=1.
  - `mem_addr` = {request tag, index, k, 2'b00}.
  - `mem_dout` is captured into word k at the edge.
  - After word W-1: valid=1, dirty=0, tag updated, next state is COMPARE. The retried request then hits.
- `hit_count`+1 on each `cpu_ready` cycle whose request is not flagged. The flag is cleared on `cpu_ready`.
- `cpu_read` and `cpu_write` both 1 is treated as a write.
- No request in COMPARE: all memory strobes are 0, and `mem_addr`, `mem_din`, `cpu_dout` and `cpu_ready` are 0.
- The CPU holds `cpu_addr`, `cpu_din` and the request strobes stable until `cpu_ready`. Any change before then is a protocol violation and is flagged by a bench assertion.

## Timing
- The hit path is fully combinational. Request in cycle 0 gives `cpu_ready` in cycle 0.
- Clean miss, W=4: FILL in cycles 1-4, `cpu_ready` in cycle 5.
- Dirty miss, W=4: WRITEBACK in cycles 1-4, FILL in cycles 5-8, `cpu_ready` in cycle 9.
- `mem_read` and `mem_write` are never both 1, and are never 1 in COMPARE.
- Reset asserted (0), asynchronously:
  - State returns to COMPARE and the word counter to 0.
  - All valid, dirty and miss-flag bits are cleared.
  - Both counters are cleared.
  - `mem_read` and `mem_write` drop to 0 in the same instant.
- A reset mid-WRITEBACK leaves memory partially updated. This is the required behaviour.
- Tag and data storage is not reset.
- Reset deasserted: the first edge-triggered action is at the next rising edge.

## Structure
- Package `cache_pkg` holds:
  - the state enum (COMPARE, WRITEBACK, FILL);
  - offset, index and tag width localparams derived from the parameters;
  - address slicing and compose functions for the tag/index/offset fields.
- One sub-module, `cache_line_array`:
  - valid, dirty, tag and data storage;
  - asynchronous read by index;
  - synchronous word write and synchronous tag/valid/dirty update;
  - asynchronous clear of valid and dirty only.
- `data_cache` keeps the FSM, the word counter, the miss flag and the counters.

## Test plan
- **Cold read miss:** memory preloaded with 0x10+k at word k; read 0x0000_0008 → 4 FILL cycles on addresses 0x0,0x4,0x8,0xC; `cpu_ready` in cycle 5 with `cpu_dout`=0x12; `miss_count`=1, `hit_count`=0.
- **Read hit after fill:** read 0x0000_000C → same-cycle `cpu_ready`, `cpu_dout`=0x13; `hit_count`=1.
- **Write hit then dirty eviction:** write 0xDEAD_BEEF to 0x4 (hit, no memory traffic); read 0x0000_0100 (same index, NUM_SETS=16, W=4) → WRITEBACK writes 0x10,0xDEADBEEF,0x12,0x13 to 0x0-0xC; then FILL from 0x100-0x10C; `cpu_ready` in cycle 9.
- **Write miss, clean victim:** write 0x5555_5555 to 0x0000_0204 → FILL only, then the write completes; a later read of 0x204 hits and returns 0x55555555; memory word at 0x204 is unchanged.
- **Reset mid-FILL:** assert reset in FILL cycle 2 → `mem_read`=0 immediately, counters=0; after release, the prior address misses again.
- **Idle:** no request for 10 cycles → all `mem_*` outputs 0, counters unchanged.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and address helpers for the direct-mapped data cache.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package cache_pkg;

  typedef enum logic [1:0] {
    COMPARE   = 2'd0,
    WRITEBACK = 2'd1,
    FILL      = 2'd2
  } state_t;

  localparam int DEF_NUM_SETS       = 16;
  localparam int DEF_WORDS_PER_LINE = 4;

  // Field widths for an arbitrary geometry; callers evaluate these as
  // constants from their own parameters.
  function automatic int off_bits(input int wpl);
    return 2 + $clog2(wpl);
  endfunction

  function automatic int idx_bits(input int ns);
    return $clog2(ns);
  endfunction

  function automatic int tag_bits(input int ns, input int wpl);
    return 32 - off_bits(wpl) - idx_bits(ns);
  endfunction

  localparam int OFF_W = off_bits(DEF_WORDS_PER_LINE);
  localparam int IDX_W = idx_bits(DEF_NUM_SETS);
  localparam int TAG_W = tag_bits(DEF_NUM_SETS, DEF_WORDS_PER_LINE);

  // Field extraction; results are right-justified, callers size-cast them.
  function automatic logic [31:0] addr_tag(input logic [31:0] a, input int ns, input int wpl);
    return a >> (off_bits(wpl) + idx_bits(ns));
  endfunction

  function automatic logic [31:0] addr_index(input logic [31:0] a, input int ns, input int wpl);
    return (a >> off_bits(wpl)) & 32'(ns - 1);
  endfunction

  function automatic logic [31:0] addr_word(input logic [31:0] a, input int wpl);
    return (a >> 2) & 32'(wpl - 1);
  endfunction

  // Rebuild a word-aligned byte address from its fields.
  function automatic logic [31:0] compose_addr(input logic [31:0] tag, input logic [31:0] idx,
                                               input logic [31:0] word, input int ns, input int wpl);
    return (tag << (off_bits(wpl) + idx_bits(ns))) | (idx << off_bits(wpl)) | (word << 2);
  endfunction

endpackage

// File: rtl/cache_line_array.sv
// Line storage: valid/dirty bits, tags and data words, one line per set.
// Latency: reads are combinational by index/word; writes land at the rising edge.
// Backpressure: none; the owning controller sequences all accesses.
// Ports: index/word_sel select the line and word; rd_* return that line's
// state; word_we/word_wdata write one word; meta_we updates valid/dirty/tag.
module cache_line_array
  import cache_pkg::*;
#(
  parameter int NUM_SETS       = DEF_NUM_SETS,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
  parameter int IDX_W_P        = idx_bits(NUM_SETS),
  parameter int WB_P           = $clog2(WORDS_PER_LINE),
  parameter int TAG_W_P        = tag_bits(NUM_SETS, WORDS_PER_LINE)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [IDX_W_P-1:0] index,
  input  logic [WB_P-1:0]    word_sel,
  output logic               rd_valid,
  output logic               rd_dirty,
  output logic [TAG_W_P-1:0] rd_tag,
  output logic [31:0]        rd_word,
  input  logic               word_we,
  input  logic [31:0]        word_wdata,
  input  logic               meta_we,
  input  logic               meta_valid,
  input  logic               meta_dirty,
  input  logic [TAG_W_P-1:0] meta_tag
);

  logic [NUM_SETS-1:0] valid_q;
  logic [NUM_SETS-1:0] dirty_q;
  logic [TAG_W_P-1:0]  tag_q  [NUM_SETS];
  logic [31:0]         data_q [NUM_SETS][WORDS_PER_LINE];

  assign rd_valid = valid_q[index];
  assign rd_dirty = dirty_q[index];
  assign rd_tag   = tag_q[index];
  assign rd_word  = data_q[index][word_sel];

  // Only the status bits are cleared; stale tags/data are harmless once invalid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (meta_we) begin
      valid_q[index] <= meta_valid;
      dirty_q[index] <= meta_dirty;
    end
  end

  always_ff @(posedge clk) begin
    if (meta_we) tag_q[index] <= meta_tag;
    if (word_we) data_q[index][word_sel] <= word_wdata;
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-back write-allocate data cache between CPU and word memory.
// Latency: hits complete in the request cycle; clean miss W+1, dirty miss 2W+1 cycles.
// Backpressure: cpu_ready low stalls the CPU during write-back and line fill.
// Ports: cpu_* is the load/store request side, mem_* drives the word memory
// (mem_dout is combinational), hit_count/miss_count are free-running statistics.
module data_cache
  import cache_pkg::*;
#(
  parameter int NUM_SETS       = DEF_NUM_SETS,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_din,
  input  logic        cpu_read,
  input  logic        cpu_write,
  output logic [31:0] cpu_dout,
  output logic        cpu_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_dout,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int IW = idx_bits(NUM_SETS);
  localparam int WB = $clog2(WORDS_PER_LINE);
  localparam int TW = tag_bits(NUM_SETS, WORDS_PER_LINE);

  state_t        state_q;
  logic [WB-1:0] cnt_q;
  logic          miss_flag_q;
  logic [31:0]   hit_q;
  logic [31:0]   miss_q;

  logic          req;
  logic          hit;
  logic          last;
  logic [TW-1:0] req_tag;
  logic [IW-1:0] req_idx;
  logic [WB-1:0] req_word;
  logic [WB-1:0] word_sel;

  logic          rd_valid;
  logic          rd_dirty;
  logic [TW-1:0] rd_tag;
  logic [31:0]   rd_word;
  logic          word_we;
  logic [31:0]   word_wdata;
  logic          meta_we;
  logic          meta_valid;
  logic          meta_dirty;
  logic [TW-1:0] meta_tag;

  assign req      = cpu_read | cpu_write;
  assign req_tag  = TW'(addr_tag(cpu_addr, NUM_SETS, WORDS_PER_LINE));
  assign req_idx  = IW'(addr_index(cpu_addr, NUM_SETS, WORDS_PER_LINE));
  assign req_word = WB'(addr_word(cpu_addr, WORDS_PER_LINE));
  assign hit      = (state_q == COMPARE) && req && rd_valid && (rd_tag == req_tag);
  assign last     = (cnt_q == WB'(WORDS_PER_LINE - 1));
  // The request word is addressed in COMPARE; the burst counter drives it otherwise.
  assign word_sel = (state_q == COMPARE) ? req_word : cnt_q;

  assign hit_count  = hit_q;
  assign miss_count = miss_q;

  cache_line_array #(
    .NUM_SETS       (NUM_SETS),
    .WORDS_PER_LINE (WORDS_PER_LINE),
    .IDX_W_P        (IW),
    .WB_P           (WB),
    .TAG_W_P        (TW)
  ) u_lines (
    .clk        (clk),
    .reset      (reset),
    .index      (req_idx),
    .word_sel   (word_sel),
    .rd_valid   (rd_valid),
    .rd_dirty   (rd_dirty),
    .rd_tag     (rd_tag),
    .rd_word    (rd_word),
    .word_we    (word_we),
    .word_wdata (word_wdata),
    .meta_we    (meta_we),
    .meta_valid (meta_valid),
    .meta_dirty (meta_dirty),
    .meta_tag   (meta_tag)
  );

  always_comb begin
    cpu_dout   = 32'h0;
    cpu_ready  = 1'b0;
    mem_addr   = 32'h0;
    mem_din    = 32'h0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    word_we    = 1'b0;
    word_wdata = 32'h0;
    meta_we    = 1'b0;
    meta_valid = 1'b0;
    meta_dirty = 1'b0;
    meta_tag   = req_tag;
    case (state_q)
      COMPARE: begin
        if (hit) begin
          cpu_ready = 1'b1;
          if (cpu_read) cpu_dout = rd_word;
          // Read+write together behaves as a store.
          if (cpu_write) begin
            word_we    = 1'b1;
            word_wdata = cpu_din;
            meta_we    = 1'b1;
            meta_valid = 1'b1;
            meta_dirty = 1'b1;
          end
        end
      end
      WRITEBACK: begin
        mem_write = 1'b1;
        mem_addr  = compose_addr(32'(rd_tag), 32'(req_idx), 32'(cnt_q), NUM_SETS, WORDS_PER_LINE);
        mem_din   = rd_word;
      end
      FILL: begin
        mem_read   = 1'b1;
        mem_addr   = compose_addr(32'(req_tag), 32'(req_idx), 32'(cnt_q), NUM_SETS, WORDS_PER_LINE);
        word_we    = 1'b1;
        word_wdata = mem_dout;
        if (last) begin
          meta_we    = 1'b1;
          meta_valid = 1'b1;
          meta_dirty = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= COMPARE;
      cnt_q       <= '0;
      miss_flag_q <= 1'b0;
      hit_q       <= 32'h0;
      miss_q      <= 32'h0;
    end else begin
      case (state_q)
        COMPARE: begin
          if (req) begin
            if (hit) begin
              // A retried miss completing here is not a fresh hit.
              if (!miss_flag_q) hit_q <= hit_q + 32'd1;
              miss_flag_q <= 1'b0;
            end else begin
              miss_q      <= miss_q + 32'd1;
              miss_flag_q <= 1'b1;
              cnt_q       <= '0;
              state_q     <= (rd_valid && rd_dirty) ? WRITEBACK : FILL;
            end
          end
        end
        WRITEBACK: begin
          // Counter wraps to 0 after the last word, ready for the fill burst.
          cnt_q <= cnt_q + 1'b1;
          if (last) state_q <= FILL;
        end
        FILL: begin
          cnt_q <= cnt_q + 1'b1;
          if (last) state_q <= COMPARE;
        end
        default: state_q <= COMPARE;
      endcase
    end
  end

endmodule
